// File: rtl/rng_address_unit.sv
// rng_address_unit
// Responder for the winner-policy random-selection protocol.
// A free-running 16-bit Fibonacci LFSR answers en_rng requests. A separate
// four-state FSM computes which mod betterNeighborCount using a restoring
// remainder loop that retires one dividend bit per cycle.
module rng_address_unit #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clock,
    input  logic        nrst,
    input  logic        en_rng,
    output logic [15:0] rng_out,
    output logic [15:0] rng_out_4bit,
    input  logic        start_rngAddress,
    input  logic [15:0] which,
    input  logic [15:0] betterNeighborCount,
    output logic [15:0] rng_address,
    output logic        done_rng_address,
    output logic        div_by_zero,
    output logic        busy
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DIV      = 2'd1;
    localparam logic [1:0] S_DONE     = 2'd2;
    localparam logic [1:0] S_WAIT_LOW = 2'd3;

    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] dividend_q, dividend_d;
    logic [15:0] divisor_q, divisor_d;
    logic [15:0] rem_q, rem_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        lfsr_fb;
    logic [16:0] rem_shift;
    logic [15:0] rem_sub;
    logic [15:0] rem_step;

    // LFSR next state: taps 16/14/13/11, shifting toward bit 0.
    always_comb begin
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = en_rng ? {lfsr_fb, lfsr_q[15:1]} : lfsr_q;
    end

    // One restoring-remainder step. The dividend register shifts left so its
    // MSB is always the next bit to bring down. When the shifted remainder is
    // at least V, the true difference is below V and therefore fits in 16 bits.
    always_comb begin
        rem_shift = {rem_q, dividend_q[15]};
        rem_sub   = rem_shift[15:0] - divisor_q;
        rem_step  = (rem_shift >= {1'b0, divisor_q}) ? rem_sub : rem_shift[15:0];
    end

    // Address FSM next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        done_d     = done_q;
        dbz_d      = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start_rngAddress) begin
                    dividend_d = which;
                    divisor_d  = betterNeighborCount;
                    rem_d      = 16'd0;
                    cnt_d      = 4'd0;
                    state_d    = S_DIV;
                end
            end
            S_DIV: begin
                rem_d      = rem_step;
                dividend_d = {dividend_q[14:0], 1'b0};
                cnt_d      = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    // A zero divisor forces the published remainder to 0.
                    addr_d  = (divisor_q == 16'd0) ? 16'd0 : rem_step;
                    done_d  = 1'b1;
                    dbz_d   = (divisor_q == 16'd0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                dbz_d   = 1'b0;
                state_d = start_rngAddress ? S_WAIT_LOW : S_IDLE;
            end
            default: begin
                // A held start must be released before a new request counts.
                if (!start_rngAddress) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            lfsr_q     <= SEED;
            state_q    <= S_IDLE;
            dividend_q <= 16'd0;
            divisor_q  <= 16'd0;
            rem_q      <= 16'd0;
            cnt_q      <= 4'd0;
            addr_q     <= 16'd0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            lfsr_q     <= lfsr_d;
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    assign rng_out          = lfsr_q;
    assign rng_out_4bit     = {12'd0, lfsr_q[3:0]};
    assign rng_address      = addr_q;
    assign done_rng_address = done_q;
    assign div_by_zero      = dbz_q;
    assign busy             = (state_q == S_DIV) || (state_q == S_DONE);

endmodule

// File: tb/tb_rng_address_unit.sv
// Self-checking bench for rng_address_unit: directed steps push expected
// remainders into a scoreboard; a negedge monitor pops them on each done pulse.
module tb_rng_address_unit;

    localparam logic [15:0] SEED = 16'hACE1;

    logic        clock = 1'b0;
    logic        nrst;
    logic        en_rng;
    logic [15:0] rng_out;
    logic [15:0] rng_out_4bit;
    logic        start_rngAddress;
    logic [15:0] which;
    logic [15:0] betterNeighborCount;
    logic [15:0] rng_address;
    logic        done_rng_address;
    logic        div_by_zero;
    logic        busy;

    typedef struct {
        logic [15:0] addr;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cycle_cnt = 0;
    int          done_cnt = 0;
    bit          mon_en = 1'b0;
    logic [15:0] lfsr_model;

    rng_address_unit #(.SEED(SEED)) dut (
        .clock               (clock),
        .nrst                (nrst),
        .en_rng              (en_rng),
        .rng_out             (rng_out),
        .rng_out_4bit        (rng_out_4bit),
        .start_rngAddress    (start_rngAddress),
        .which               (which),
        .betterNeighborCount (betterNeighborCount),
        .rng_address         (rng_address),
        .done_rng_address    (done_rng_address),
        .div_by_zero         (div_by_zero),
        .busy                (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: pass the rising edge, advance the LFSR model, stop at the falling edge.
    task automatic clk_step();
        @(posedge clock);
        if (en_rng) lfsr_model = lfsr_step(lfsr_model);
        @(negedge clock);
    endtask

    // Raise start with operands and record the expected result and done cycle.
    task automatic start_div(input logic [15:0] w, input logic [15:0] c);
        exp_t e;
        which               = w;
        betterNeighborCount = c;
        start_rngAddress    = 1'b1;
        e.addr = (c == 16'd0) ? 16'd0 : (w % c);
        e.dbz  = (c == 16'd0);
        e.due  = cycle_cnt + 17;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_rng_address !== 1'b1 && n < 40) begin
            clk_step();
            n++;
        end
        check("done_timeout", {31'd0, done_rng_address}, 32'd1);
    endtask

    task automatic run_div(input logic [15:0] w, input logic [15:0] c);
        start_div(w, c);
        clk_step();
        check("busy_in_div", {31'd0, busy}, 32'd1);
        wait_done();
        start_rngAddress = 1'b0;
        clk_step();
        clk_step();
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard monitor: compares every done pulse against the oldest expectation.
    always @(negedge clock) begin
        if (mon_en) begin
            if (done_rng_address === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL spurious_done: observed=1 expected=0 cycle=%0d", cycle_cnt);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("txn: cycle=%0d rng_address=%0d div_by_zero=%0b exp_addr=%0d exp_dbz=%0b exp_cycle=%0d",
                             cycle_cnt, rng_address, div_by_zero, e.addr, e.dbz, e.due);
                    check("rng_address", {16'd0, rng_address}, {16'd0, e.addr});
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                    check("latency", cycle_cnt, e.due);
                end
            end else begin
                check("dbz_outside_done", {31'd0, div_by_zero}, 32'd0);
            end
        end
    end

    initial begin
        int d0;
        nrst                = 1'b0;
        en_rng              = 1'b0;
        start_rngAddress    = 1'b0;
        which               = 16'd0;
        betterNeighborCount = 16'd0;
        lfsr_model          = SEED;
        repeat (3) clk_step();
        mon_en = 1'b1;

        check("rst_rng_out", {16'd0, rng_out}, 32'h0000ACE1);
        check("rst_rng_out_4bit", {16'd0, rng_out_4bit}, 32'h1);
        check("rst_rng_address", {16'd0, rng_address}, 32'd0);
        check("rst_done", {31'd0, done_rng_address}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        nrst = 1'b1;

        // LFSR: two enabled edges.
        en_rng = 1'b1;
        clk_step();
        check("lfsr_step1", {16'd0, rng_out}, 32'h5670);
        check("lfsr_4bit1", {16'd0, rng_out_4bit}, 32'h0);
        clk_step();
        check("lfsr_step2", {16'd0, rng_out}, 32'hAB38);
        check("lfsr_4bit2", {16'd0, rng_out_4bit}, 32'h8);
        en_rng = 1'b0;
        clk_step();
        check("lfsr_hold", {16'd0, rng_out}, {16'd0, lfsr_model});

        // Basic divisions, including a divisor of 1 and a zero divisor.
        run_div(16'd13, 16'd5);
        run_div(16'd3, 16'd7);
        run_div(16'hFFFF, 16'd1);
        run_div(16'd9, 16'd0);
        run_div(16'hBEEF, 16'd1234);

        // Start held for 40 cycles yields exactly one done pulse.
        d0 = done_cnt;
        start_div(16'd20, 16'd6);
        repeat (40) clk_step();
        check("held_start_one_done", done_cnt - d0, 32'd1);
        check("busy_wait_low", {31'd0, busy}, 32'd0);
        start_rngAddress = 1'b0;
        clk_step();
        start_div(16'd14, 16'd4);
        wait_done();
        start_rngAddress = 1'b0;
        clk_step();
        clk_step();

        // Operands change mid-division while en_rng toggles.
        start_div(16'd100, 16'd7);
        repeat (4) clk_step();
        which               = 16'd55;
        betterNeighborCount = 16'd3;
        for (int k = 0; k < 10; k++) begin
            en_rng = 1'($urandom_range(0, 1));
            clk_step();
        end
        en_rng = 1'b0;
        wait_done();
        start_rngAddress = 1'b0;
        clk_step();
        clk_step();
        check("lfsr_during_div", {16'd0, rng_out}, {16'd0, lfsr_model});

        // Reset at edge N+8 of a division: no done, outputs return to reset values.
        d0 = done_cnt;
        start_div(16'd1000, 16'd33);
        repeat (8) clk_step();
        nrst             = 1'b0;
        start_rngAddress = 1'b0;
        sb.delete();
        clk_step();
        lfsr_model = SEED;
        check("midrst_rng_out", {16'd0, rng_out}, {16'd0, SEED});
        check("midrst_rng_address", {16'd0, rng_address}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done_rng_address}, 32'd0);
        nrst = 1'b1;
        repeat (20) clk_step();
        check("midrst_no_done", done_cnt - d0, 32'd0);

        // A division after the reset still works.
        run_div(16'd77, 16'd10);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rng_address_unit.md
# rng_address_unit

Responder side of the winner-policy random-selection protocol. Answers `en_rng` requests with a 16-bit LFSR value plus a 4-bit slice. Answers the `start_rngAddress`/`done_rng_address` handshake by computing `rng_address = which mod betterNeighborCount`. This is the index the initiator scales into the betterNeighbor table (`0x668 + 2*index`). Sits beside the winner-policy FSM in the node top, sharing its clock and reset.

## Interface

Parameters:
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clock` in 1: rising-edge clock.
- `nrst` in 1: reset, synchronous, active-low.
- `en_rng` in 1: LFSR advances one step on each rising edge where high.
- `rng_out` out 16: current LFSR state (registered).
- `rng_out_4bit` out 16: {12'b0, rng_out[3:0]}.
- `start_rngAddress` in 1: level request; initiator holds it until it sees done.
- `which` in 16: dividend; latched on start acceptance.
- `betterNeighborCount` in 16: divisor; latched on start acceptance.
- `rng_address` out 16: remainder result; holds until the next result or reset.
- `done_rng_address` out 1: one-cycle result-valid pulse.
- `div_by_zero` out 1: high with done when the latched count was 0.
- `busy` out 1: high in DIV and DONE states.

## Operation

- Reset (`nrst` = 0 at an edge) clears all outputs and state:
  - `rng_out` = SEED.
  - `rng_address` = 0.
  - `done_rng_address`, `div_by_zero` and `busy` = 0.
  - State = IDLE, bit counter = 0.
  - Reset has priority over every other input.
- LFSR, Fibonacci form, taps 16/14/13/11:
  - fb = s[0]^s[2]^s[3]^s[5].
  - next = {fb, s[15:1]}.
  - Runs independently of the address FSM; both may be active in the same cycle.
- The FSM has four states: IDLE, DIV, DONE, WAIT_LOW.
- IDLE:
  - When start = 1, latch `which` into the dividend register D and `betterNeighborCount` into the divisor register V.
  - Clear the 17-bit remainder R and the counter i, then go to DIV.
  - Otherwise stay in IDLE.
- DIV performs a restoring remainder, one bit per cycle, for exactly 16 cycles:
  - R' = {R[15:0], D[15-i]}.
  - If R' ≥ {1'b0, V}, R = R' − V; otherwise R = R'.
  - i increments each cycle.
  - After i = 15, register `rng_address` = R[15:0] and set `done_rng_address` = 1.
  - Set `div_by_zero` = (V == 0) and go to DONE.
- Zero divisor:
  - With V = 0 the remainder path is forced so that `rng_address` = 0.
  - The cycle count is unchanged; the block never stalls.
- DONE (one cycle):
  - Clear `done_rng_address` and `div_by_zero`.
  - Go to IDLE if start = 0, otherwise go to WAIT_LOW.
- WAIT_LOW: stay while start = 1; go to IDLE when start = 0. A held start never retriggers.
- Inputs `which` and `betterNeighborCount` changing after acceptance have no effect on the result in flight.
- Result range: `rng_address` < `betterNeighborCount` whenever count ≠ 0.

## Timing

- Start sampled high at edge N:
  - DIV occupies edges N+1..N+16.
  - `done_rng_address` is high for exactly the cycle between edges N+16 and N+17 (17-cycle latency).
- `rng_address` becomes valid at edge N+16, is stable while done is high, and holds afterwards.
- Minimum spacing between two accepted starts: start must be observed low for at least one edge after DONE.
- LFSR timing:
  - `en_rng` high at edge M makes `rng_out` change at edge M.
  - An initiator sampling at edge M sees the pre-step value.
  - Asserting `en_rng` for k edges yields k steps.
- Reset mid-DIV: the result is discarded and no done pulse is produced. After reset release, a start still held high is accepted as a new request.

## Test plan

- Reset, then `en_rng` = 1 for 2 edges -> `rng_out` goes 0xACE1 → 0x5670 → 0xAB38; `rng_out_4bit` goes 0x1 → 0x0 → 0x8.
- which = 13, count = 5, start raised at edge N -> done high only in the cycle after edge N+16, `rng_address` = 3, `div_by_zero` = 0.
- which = 3, count = 7 -> `rng_address` = 3. which = 0xFFFF, count = 1 -> `rng_address` = 0, latency 17.
- count = 0, which = 9 -> `rng_address` = 0, `div_by_zero` = 1 for the done cycle only, latency 17.
- Start held high for 40 cycles -> exactly one done pulse. Drop start for one cycle then raise it with which = 14, count = 4 -> second done, `rng_address` = 2.
- Additional cases:
  - Pulse `nrst` low at edge N+8 of a division -> no done pulse, all outputs at reset values.
  - Change `which` mid-DIV -> result reflects the latched value.
  - Toggle `en_rng` during DIV -> LFSR steps correctly and the result is unaffected.
